// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out shift register: captures an n-bit word on load and
// presents it MSB first on out, one bit per clock, zero-filling behind it.
module piso_shift_register #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [n-1:0] in,
    output logic         out
);

    localparam int CNT_W = $clog2(n + 1);

    logic [n-1:0]     sr_q;
    logic [n-1:0]     sr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load wins over shift; the count tracks bits still to present and saturates at zero.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = in;
            cnt_d = CNT_W'(n);
        end else begin
            sr_d = {sr_q[n-2:0], 1'b0};
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign out = sr_q[n-1];

endmodule

// File: tb/tb_piso_shift_register.sv
// Bench for piso_shift_register: n=8 and n=4 instances against a queue-based
// model of the bits still to be presented, plus literal directed sequences.
module tb_piso_shift_register;

    logic       clk = 1'b0;
    logic       reset;
    logic       load8 = 1'b0;
    logic [7:0] in8 = '0;
    logic       out8;
    logic       load4 = 1'b0;
    logic [3:0] in4 = '0;
    logic       out4;
    logic       chk_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    piso_shift_register #(.n(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .load  (load8),
        .in    (in8),
        .out   (out8)
    );

    piso_shift_register #(.n(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .load  (load4),
        .in    (in4),
        .out   (out4)
    );

    always #5 clk = ~clk;

    // Model: the ordered list of bits the line has yet to show; head is on out now.
    bit q8[$];
    bit q4[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q8.delete();
            q4.delete();
        end else begin
            if (load8) begin
                q8.delete();
                for (int k = 7; k >= 0; k--) q8.push_back(in8[k]);
            end else if (q8.size() > 0) begin
                void'(q8.pop_front());
            end
            if (load4) begin
                q4.delete();
                for (int k = 3; k >= 0; k--) q4.push_back(in4[k]);
            end else if (q4.size() > 0) begin
                void'(q4.pop_front());
            end
        end
    end

    function automatic logic model_out8();
        return (q8.size() > 0) ? q8[0] : 1'b0;
    endfunction

    function automatic logic model_out4();
        return (q4.size() > 0) ? q4[0] : 1'b0;
    endfunction

    task automatic check(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model8", out8, model_out8());
            check("model4", out4, model_out4());
        end
    end

    initial begin
        logic [7:0] p8;
        logic [3:0] p4;

        // Reset held with load active: nothing gets through
        reset = 1'b1;
        #1 reset = 1'b0;
        load8 = 1'b1; in8 = 8'hFF;
        load4 = 1'b1; in4 = 4'hF;
        chk_en = 1'b1;
        #1 check("rst_async", out8, 1'b0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold8", out8, 1'b0);
            check("rst_hold4", out4, 1'b0);
        end
        reset = 1'b1;
        load8 = 1'b0;
        load4 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst8", out8, 1'b0);
            check("post_rst4", out4, 1'b0);
        end

        // Basic serialise on both widths
        p8 = 8'b10101011;
        p4 = 4'b1001;
        load8 = 1'b1; in8 = p8;
        load4 = 1'b1; in4 = p4;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            load8 = 1'b0;
            load4 = 1'b0;
            check("basic8", out8, (i < 8) ? p8[7-i] : 1'b0);
            check("basic4", out4, (i < 4) ? p4[3-i] : 1'b0);
        end

        // Reload mid-stream
        load8 = 1'b1; in8 = 8'hF0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reload_a", out8, 1'b1);
            load8 = (i == 3);
            in8   = 8'h0F;
        end
        p8 = 8'h0F;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            load8 = 1'b0;
            check("reload_b", out8, (i < 8) ? p8[7-i] : 1'b0);
        end

        // Load held high for four edges
        load8 = 1'b1; in8 = 8'h80;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("held", out8, 1'b1);
            load8 = (i < 3);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("held_after", out8, 1'b0);
        end

        // Asynchronous reset mid-stream, between edges
        load8 = 1'b1; in8 = 8'hFF;
        @(negedge clk);
        load8 = 1'b0;
        check("arst_pre0", out8, 1'b1);
        @(negedge clk);
        check("arst_pre1", out8, 1'b1);
        @(negedge clk);
        check("arst_pre2", out8, 1'b1);
        #2 reset = 1'b0;
        #1 check("arst_now", out8, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("arst_after", out8, 1'b0);
        end

        // Randomised traffic, including occasional async reset pulses
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            load8 = ($urandom_range(3) == 0);
            in8   = 8'($urandom);
            load4 = ($urandom_range(4) == 0);
            in4   = 4'($urandom);
            if ($urandom_range(79) == 0) begin
                #2 reset = 1'b0;
                #1 check("rnd_arst8", out8, 1'b0);
                check("rnd_arst4", out4, 1'b0);
                reset = 1'b1;
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
